pcu_ras: RTL and testbench
==========================

Name: pcu_ras

Overview:
Parametrised next-generation program counter unit for the MIPS core's fetch stage. It generates the fetch PC with a fixed redirect priority: exception, ERET, jump, branch, predicted return, stall, sequential. It also holds an EPC register and a circular return-address stack (RAS) for predicting `jr $ra`. Decode drives the redirect and control inputs; the PC output feeds instruction memory.

Parameters:
WIDTH, 32, PC/address width in bits.
RESET_PC, 32'h0000_3000, PC value after reset.
EXC_VEC, 32'h0000_4180, exception entry address.
INC, 4, sequential increment in bytes.
RAS_DEPTH, 4, number of RAS entries; power of 2, minimum 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low.
stall  in  1  hazard; hold PC, suppress call/ret.
exc_req  in  1  take exception this cycle.
exc_pc  in  WIDTH  faulting instruction PC, captured into EPC.
eret  in  1  return from exception.
jump  in  1  unconditional jump redirect.
jump_addr  in  WIDTH  jump target.
branch_taken  in  1  resolved taken branch; also used for RAS mispredict correction.
branch_addr  in  WIDTH  branch or correction target.
call  in  1  push link_addr onto RAS (jal/jalr).
link_addr  in  WIDTH  return address to push.
ret  in  1  predicted return; pop RAS and redirect to the popped value.
pc  out  WIDTH  current fetch PC (registered).
epc  out  WIDTH  exception PC (registered).
ras_empty  out  1  RAS count == 0.
ras_full  out  1  RAS count == RAS_DEPTH.
ret_hit  out  1  registered; 1 the cycle after a ret that was served from a non-empty RAS.

Behaviour:
- Reset (rst==0 at a clk edge): pc=RESET_PC, epc=0, RAS count=0, top pointer=0, ret_hit=0, all RAS entries=0. Reset overrides every other input in that cycle.
- Next-PC priority, first match wins. pc updates one cycle after the inputs are sampled:
  1. exc_req: pc<=EXC_VEC, epc<=exc_pc.
  2. eret: pc<=epc.
  3. jump: pc<=jump_addr.
  4. branch_taken: pc<=branch_addr.
  5. ret and !stall and RAS not empty: pc<=RAS top.
  6. stall: pc holds.
  7. Otherwise: pc<=pc+INC, wrapping mod 2^WIDTH.
- Bits [1:0] of every redirect target and of epc are forced to 0.
- Redirects 1-4 override stall, as in the previous-generation PC unit.
- RAS update rules:
  - Suppressed entirely when stall, exc_req or eret is 1.
  - Push (call only): top pointer advances, entry<=link_addr, count saturates at RAS_DEPTH. Pushing when full overwrites the oldest entry (circular).
  - Pop (ret only, count>0): returns the top entry, pointer retreats, count decrements.
  - Pop when empty: no pointer or count change, no redirect, ret_hit=0. pc follows the lower-priority rules.
  - call and ret in the same cycle: the top entry is replaced with link_addr; pointer and count are unchanged. The redirect uses the old top.
  - ret while jump or branch_taken is 1: the RAS still pops, but the higher-priority redirect wins the PC.
- ret_hit <= (ret & !stall & !exc_req & !eret & count>0). Cleared otherwise.
- Pointer arithmetic is modulo RAS_DEPTH, with log2(RAS_DEPTH) bits. Count uses log2(RAS_DEPTH)+1 bits.
- No combinational path from any input to pc or epc.

Decomposition:
- Shared package `mips_pkg`:
  - RESET_PC and EXC_VEC constants.
  - `pc_sel_e` enum: EXC, ERET, JMP, BR, RET, HOLD, SEQ.
  - clog2 helper for the pointer width.
- Sub-module `ras_stack`: the circular stack with push, pop, replace, saturating count, and empty/full flags. pcu_ras contains the next-PC priority mux, the PC register and the EPC register.

Test Plan:
- Reset: hold rst=0 for 2 cycles with jump=1, then release -> pc=0x3000 for the cycles with rst=0; then 0x3004, 0x3008; epc=0, ras_empty=1.
- Priority: assert exc_req, jump and branch_taken together with exc_pc=0x3010 -> next pc=0x4180, epc=0x3010. Then eret -> pc=0x3010. Then stall+jump to 0x5000 -> pc=0x5000.
- RAS basic: call with link 0x3104, call with link 0x3208, then ret -> pc=0x3208, ret_hit=1; ret again -> pc=0x3104; ras_empty=1.
- RAS overflow (RAS_DEPTH=4): push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 -> ras_full=1. Four rets yield 0xE0, 0xD0, 0xC0, 0xB0. A fifth ret -> no redirect, pc sequential, ret_hit=0.
- Simultaneous and stall: top=0x100; call(0x200)+ret same cycle -> redirect 0x100, next ret -> 0x200, count unchanged. ret with stall=1 -> pc holds, RAS unchanged.
- Wrap: pc=0xFFFF_FFFC with no redirect -> pc=0x0000_0000. jump_addr=0x3007 -> pc=0x3004.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants, PC-select encoding and a width helper for the fetch-stage
// PC unit and its return-address stack.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  typedef enum logic [2:0] {
    EXC,
    ERET,
    JMP,
    BR,
    RET,
    HOLD,
    SEQ
  } pc_sel_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop, same-cycle replace, saturating
// count. When full, a push silently overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  import mips_pkg::*;

  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW + 1)'(DEPTH);

  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok;

  assign pop_ok  = pop & (cnt_q != '0);
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push && pop_ok) begin
      // call+ret together: the return consumes the old top, the call refills it
      mem_d[ptr_q] = wdata;
    end else if (push) begin
      ptr_d          = ptr_inc;
      mem_d[ptr_inc] = wdata;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (pop_ok) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pcu_ras.sv
// Fetch-stage PC unit: fixed-priority next-PC mux, PC and EPC registers, and
// a return-address stack predicting `jr $ra`.
module pcu_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(mips_pkg::RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(mips_pkg::EXC_VEC),
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic             call,
  input  logic [WIDTH-1:0] link_addr,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_hit
);
  import mips_pkg::*;

  localparam logic [WIDTH-1:0] ALIGN = ~(WIDTH'(3));

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             ret_hit_q, ret_hit_d;
  logic [WIDTH-1:0] ras_top;
  logic             ras_en, ras_push, ras_pop, ret_ok;
  pc_sel_e          sel;

  // Exceptions and ERET freeze the stack; stalls freeze it too so a replayed
  // call/ret is not counted twice.
  assign ras_en   = ~stall & ~exc_req & ~eret;
  assign ras_push = call & ras_en;
  assign ras_pop  = ret & ras_en & ~ras_empty;
  assign ret_ok   = ret & ~stall & ~ras_empty;

  ras_stack #(
    .WIDTH(WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (ras_push),
    .pop  (ras_pop),
    .wdata(link_addr),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );

  always_comb begin
    sel = SEQ;
    if (exc_req)           sel = EXC;
    else if (eret)         sel = ERET;
    else if (jump)         sel = JMP;
    else if (branch_taken) sel = BR;
    else if (ret_ok)       sel = RET;
    else if (stall)        sel = HOLD;
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      EXC:     pc_d = EXC_VEC & ALIGN;
      ERET:    pc_d = epc_q;
      JMP:     pc_d = jump_addr & ALIGN;
      BR:      pc_d = branch_addr & ALIGN;
      RET:     pc_d = ras_top & ALIGN;
      HOLD:    pc_d = pc_q;
      SEQ:     pc_d = pc_q + WIDTH'(INC);
      default: pc_d = pc_q;
    endcase
    epc_d     = exc_req ? (exc_pc & ALIGN) : epc_q;
    ret_hit_d = ras_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      ret_hit_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      ret_hit_q <= ret_hit_d;
    end
  end

  assign pc      = pc_q;
  assign epc     = epc_q;
  assign ret_hit = ret_hit_q;

endmodule

// File: tb/tb_pcu_ras.sv
// Directed vector table plus randomized run against a queue-based model of pcu_ras.
module tb_pcu_ras;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 0, exc_req = 0, eret = 0, jump = 0, branch_taken = 0, call = 0, ret = 0;
  logic [31:0] exc_pc = 0, jump_addr = 0, branch_addr = 0, link_addr = 0;
  logic [31:0] pc, epc;
  logic        ras_empty, ras_full, ret_hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pcu_ras dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .exc_pc(exc_pc),
    .eret(eret), .jump(jump), .jump_addr(jump_addr), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .call(call), .link_addr(link_addr), .ret(ret),
    .pc(pc), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full), .ret_hit(ret_hit)
  );

  // ctrl bits: stall, exc_req, eret, jump, branch_taken, call, ret
  localparam logic [6:0] ST = 7'b1000000, EX = 7'b0100000, ER = 7'b0010000,
                         JP = 7'b0001000, BR = 7'b0000100, CL = 7'b0000010, RT = 7'b0000001;

  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] addr;   // drives exc_pc, jump_addr, branch_addr and link_addr alike
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    logic [2:0]  e_flags; // {ret_hit, ras_empty, ras_full}
  } vec_t;

  vec_t vecs[$];

  logic [31:0] m_pc, m_epc;
  bit          m_hit;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [6:0] c, input logic [31:0] a);
    {stall, exc_req, eret, jump, branch_taken, call, ret} = c;
    exc_pc = a; jump_addr = a; branch_addr = a; link_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: stack is a queue with the newest entry at the back.
  task automatic model_step();
    bit          has, en;
    logic [31:0] top;
    if (!rst) begin
      m_pc = 32'h0000_3000; m_epc = 0; m_hit = 0; m_ras.delete();
      return;
    end
    has   = m_ras.size() > 0;
    top   = has ? m_ras[m_ras.size()-1] : 32'h0;
    en    = !stall && !exc_req && !eret;
    m_hit = ret && en && has;
    if (exc_req) begin
      m_pc  = 32'h0000_4180;
      m_epc = exc_pc & ~32'h3;
    end else if (eret)              m_pc = m_epc;
    else if (jump)                  m_pc = jump_addr & ~32'h3;
    else if (branch_taken)          m_pc = branch_addr & ~32'h3;
    else if (ret && !stall && has)  m_pc = top & ~32'h3;
    else if (!stall)                m_pc = m_pc + 32'd4;
    if (en) begin
      if (call && ret && has) m_ras[m_ras.size()-1] = link_addr;
      else if (call) begin
        m_ras.push_back(link_addr);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (ret && has) void'(m_ras.pop_back());
    end
  endtask

  initial begin
    // Reset held with jump asserted: reset must win.
    rst = 0; apply(JP, 32'h5000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_pc", pc, 32'h3000);
      chk("reset_epc", epc, 32'h0);
      chk("reset_empty", 32'(ras_empty), 32'd1);
      chk("reset_hit", 32'(ret_hit), 32'd0);
    end
    rst = 1; apply(7'b0, 32'h0);
    tick(); chk("seq1_pc", pc, 32'h3004);
    tick(); chk("seq2_pc", pc, 32'h3008);
    chk("seq2_empty", 32'(ras_empty), 32'd1);

    vecs.push_back('{EX|JP|BR, 32'h3010, 32'h4180, 32'h3010, 3'b010});
    vecs.push_back('{ER,       32'h0,    32'h3010, 32'h3010, 3'b010});
    vecs.push_back('{ST|JP,    32'h5000, 32'h5000, 32'h3010, 3'b010});
    vecs.push_back('{ST,       32'h0,    32'h5000, 32'h3010, 3'b010});
    vecs.push_back('{CL,       32'h3104, 32'h5004, 32'h3010, 3'b000});
    vecs.push_back('{CL,       32'h3208, 32'h5008, 32'h3010, 3'b000});
    vecs.push_back('{RT,       32'h0,    32'h3208, 32'h3010, 3'b100});
    vecs.push_back('{RT,       32'h0,    32'h3104, 32'h3010, 3'b110});
    vecs.push_back('{7'b0,     32'h0,    32'h3108, 32'h3010, 3'b010});
    vecs.push_back('{CL,       32'hA0,   32'h310C, 32'h3010, 3'b000});
    vecs.push_back('{CL,       32'hB0,   32'h3110, 32'h3010, 3'b000});
    vecs.push_back('{CL,       32'hC0,   32'h3114, 32'h3010, 3'b000});
    vecs.push_back('{CL,       32'hD0,   32'h3118, 32'h3010, 3'b001});
    vecs.push_back('{CL,       32'hE0,   32'h311C, 32'h3010, 3'b001});
    vecs.push_back('{RT,       32'h0,    32'hE0,   32'h3010, 3'b100});
    vecs.push_back('{RT,       32'h0,    32'hD0,   32'h3010, 3'b100});
    vecs.push_back('{RT,       32'h0,    32'hC0,   32'h3010, 3'b100});
    vecs.push_back('{RT,       32'h0,    32'hB0,   32'h3010, 3'b110});
    vecs.push_back('{RT,       32'h0,    32'hB4,   32'h3010, 3'b010});
    vecs.push_back('{CL,       32'h100,  32'hB8,   32'h3010, 3'b000});
    vecs.push_back('{CL|RT,    32'h200,  32'h100,  32'h3010, 3'b100});
    vecs.push_back('{ST|RT,    32'h0,    32'h100,  32'h3010, 3'b000});
    vecs.push_back('{RT,       32'h0,    32'h200,  32'h3010, 3'b110});
    vecs.push_back('{CL,       32'h300,  32'h204,  32'h3010, 3'b000});
    vecs.push_back('{RT|JP,    32'h7000, 32'h7000, 32'h3010, 3'b110});
    vecs.push_back('{CL,       32'h400,  32'h7004, 32'h3010, 3'b000});
    vecs.push_back('{RT|ER,    32'h0,    32'h3010, 32'h3010, 3'b000});
    vecs.push_back('{RT,       32'h0,    32'h400,  32'h3010, 3'b110});
    vecs.push_back('{JP,       32'h3007, 32'h3004, 32'h3010, 3'b010});
    vecs.push_back('{BR,       32'h5003, 32'h5000, 32'h3010, 3'b010});
    vecs.push_back('{EX,       32'h1237, 32'h4180, 32'h1234, 3'b010});
    vecs.push_back('{JP,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1234, 3'b010});
    vecs.push_back('{7'b0,     32'h0,    32'h0,    32'h1234, 3'b010});

    foreach (vecs[i]) begin
      apply(vecs[i].ctrl, vecs[i].addr);
      tick();
      $display("vec %0d ctrl=%07b addr=0x%08h -> pc=0x%08h epc=0x%08h hit=%0b empty=%0b full=%0b",
               i, vecs[i].ctrl, vecs[i].addr, pc, epc, ret_hit, ras_empty, ras_full);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_epc", i), epc, vecs[i].e_epc);
      chk($sformatf("vec%0d_hit", i), 32'(ret_hit), 32'(vecs[i].e_flags[2]));
      chk($sformatf("vec%0d_empty", i), 32'(ras_empty), 32'(vecs[i].e_flags[1]));
      chk($sformatf("vec%0d_full", i), 32'(ras_full), 32'(vecs[i].e_flags[0]));
    end

    // Randomized run against the model, with occasional mid-run resets.
    apply(7'b0, 32'h0);
    rst = 0; model_step(); tick(); rst = 1;
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(63) != 0);
      stall        = ($urandom_range(4) == 0);
      exc_req      = ($urandom_range(15) == 0);
      eret         = ($urandom_range(15) == 0);
      jump         = ($urandom_range(7) == 0);
      branch_taken = ($urandom_range(7) == 0);
      call         = ($urandom_range(2) == 0);
      ret          = ($urandom_range(2) == 0);
      exc_pc       = $urandom;
      jump_addr    = $urandom;
      branch_addr  = $urandom;
      link_addr    = $urandom;
      model_step();
      tick();
      $display("rnd %0d rst=%0b st=%0b ex=%0b er=%0b j=%0b b=%0b c=%0b r=%0b -> pc=0x%08h exp=0x%08h",
               n, rst, stall, exc_req, eret, jump, branch_taken, call, ret, pc, m_pc);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_epc", epc, m_epc);
      chk("rnd_hit", 32'(ret_hit), 32'(m_hit));
      chk("rnd_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      chk("rnd_full", 32'(ras_full), 32'(m_ras.size() == 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
